// File: rtl/staged_mega_mux.sv
// rtl/staged_mega_mux.sv - registered N:1 operand mux with direct or round-robin scan select
module staged_mega_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH*CHANNELS-1:0] in_flat,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       chan_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_err,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] ptr_d;
   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_sel_q;
   logic             out_err_q;
   logic             out_valid_q;

   logic             load_ok;
   logic             accept;
   logic             dir_err;
   logic [SEL_W:0]   cand;
   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] pick_idx;
   logic [WIDTH-1:0] pick_data;

   // The output register may refill when empty or when it is being drained this cycle.
   assign load_ok  = !out_valid_q || out_ready;
   assign in_ready = load_ok && (!mode || (|chan_en));
   assign accept   = in_valid && in_ready;
   assign dir_err  = ({1'b0, sel} >= (SEL_W+1)'(CHANNELS));

   // Round-robin search from ptr; walking offsets downward lets the nearest enabled channel win last.
   always_comb begin
      scan_idx = '0;
      cand     = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
         if (cand >= (SEL_W+1)'(CHANNELS)) begin
            cand = cand - (SEL_W+1)'(CHANNELS);
         end
         if (chan_en[cand[SEL_W-1:0]]) begin
            scan_idx = cand[SEL_W-1:0];
         end
      end
   end

   // Pointer advances past the chosen channel, wrapping at the last channel.
   assign ptr_d = (scan_idx == SEL_W'(CHANNELS - 1)) ? '0 : scan_idx + SEL_W'(1);

   // Channel mux; an out-of-range direct select matches no channel and yields zero data.
   always_comb begin
      pick_idx  = mode ? scan_idx : sel;
      pick_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (pick_idx == SEL_W'(k)) begin
            pick_data = in_flat[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output register and scan pointer: load on accept, clear valid on a plain drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else if (accept) begin
         out_data_q  <= pick_data;
         out_sel_q   <= pick_idx;
         out_err_q   <= !mode && dir_err;
         out_valid_q <= 1'b1;
         if (mode) begin
            ptr_q <= ptr_d;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;

endmodule
